// File: rtl/param_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH bits per frame into a word
// and presents it on a valid/ready handshake with a sticky overrun flag.
module param_deserializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_valid,
   input  logic             ser_data,
   input  logic             frame_start,
   input  logic             par_ready,
   output logic [WIDTH-1:0] par_data,
   output logic             par_valid,
   output logic             busy,
   output logic [7:0]       bit_count,
   output logic             overrun
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StHold  = 2'd2;

   localparam logic [7:0] WidthCnt  = 8'(WIDTH);
   localparam bit         SingleBit = (WIDTH == 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] par_data_q, par_data_d;
   logic [7:0]       count_q, count_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] start_word;
   logic [WIDTH-1:0] next_word;
   logic [7:0]       count_inc;
   logic             start_frame;

   // Writes bit b into the slot that frame bit k maps to under the chosen bit order.
   function automatic logic [WIDTH-1:0] place_bit(input logic [WIDTH-1:0] base,
                                                  input logic [7:0]       k,
                                                  input logic             b);
      logic [WIDTH-1:0] r;
      int unsigned      pos;
      r   = base;
      pos = LSB_FIRST ? 32'(k) : (WIDTH - 1 - 32'(k));
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i == pos) begin
            r[i] = b;
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      par_data_d  = par_data_q;
      count_d     = count_q;
      overrun_d   = overrun_q;
      start_frame = 1'b0;

      start_word = place_bit('0, 8'd0, ser_data);
      next_word  = place_bit(shift_q, count_q, ser_data);
      count_inc  = count_q + 8'd1;

      case (state_q)
         StIdle: begin
            if (ser_valid && frame_start) begin
               start_frame = 1'b1;
            end
         end
         StShift: begin
            if (ser_valid) begin
               if (frame_start) begin
                  // Partial frame is silently abandoned in favour of the new one.
                  start_frame = 1'b1;
               end else begin
                  shift_d = next_word;
                  count_d = count_inc;
                  if (count_inc == WidthCnt) begin
                     state_d    = StHold;
                     par_data_d = next_word;
                  end
               end
            end
         end
         StHold: begin
            if (par_ready) begin
               if (ser_valid && frame_start) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = StIdle;
                  count_d = 8'd0;
               end
            end else if (ser_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            count_d = 8'd0;
         end
      endcase

      if (start_frame) begin
         shift_d = start_word;
         count_d = 8'd1;
         if (SingleBit) begin
            state_d    = StHold;
            par_data_d = start_word;
         end else begin
            state_d = StShift;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         par_data_q <= '0;
         count_q    <= 8'd0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         par_data_q <= par_data_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
      end
   end

   assign par_data  = par_data_q;
   assign par_valid = (state_q == StHold);
   assign busy      = (state_q == StShift);
   assign bit_count = count_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_param_deserializer.sv
// Bench for param_deserializer: two WIDTH=4 instances (LSB-first and MSB-first)
// share one stimulus stream and are compared against a frame-level model.
module tb_param_deserializer;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst, ser_valid, ser_data, frame_start, par_ready;
   logic [W-1:0] pd_lsb, pd_msb;
   logic         pv_lsb, pv_msb, busy_lsb, busy_msb, ov_lsb, ov_msb;
   logic [7:0]   bc_lsb, bc_msb;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model state: bits of the frame in progress, plus the held words.
   bit           m_bits[$];
   bit           m_hold;
   logic [W-1:0] m_word_lsb, m_word_msb;
   bit           m_overrun;

   param_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data),
      .frame_start(frame_start), .par_ready(par_ready), .par_data(pd_lsb),
      .par_valid(pv_lsb), .busy(busy_lsb), .bit_count(bc_lsb), .overrun(ov_lsb)
   );

   param_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data),
      .frame_start(frame_start), .par_ready(par_ready), .par_data(pd_msb),
      .par_valid(pv_msb), .busy(busy_msb), .bit_count(bc_msb), .overrun(ov_msb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Property checks away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("prop_no_busy_and_valid", 32'(busy_lsb & pv_lsb), 32'd0);
         if (pv_msb) chk("prop_valid_count", 32'(bc_msb), W);
      end
   end

   task automatic model_update(input bit r, input bit sv, input bit sd, input bit fs,
                               input bit pr);
      if (r) begin
         m_bits.delete();
         m_hold     = 1'b0;
         m_word_lsb = '0;
         m_word_msb = '0;
         m_overrun  = 1'b0;
         return;
      end
      if (m_hold) begin
         if (pr) begin
            m_hold = 1'b0;
            m_bits.delete();
            if (sv && fs) m_bits.push_back(sd);
         end else if (sv) begin
            m_overrun = 1'b1;
         end
      end else if (sv && fs) begin
         m_bits.delete();
         m_bits.push_back(sd);
      end else if (sv && m_bits.size() > 0) begin
         m_bits.push_back(sd);
      end
      if (!m_hold && m_bits.size() == W) begin
         m_word_lsb = '0;
         m_word_msb = '0;
         for (int k = 0; k < W; k++) begin
            m_word_lsb = m_word_lsb | (W'(m_bits[k]) << k);
            m_word_msb = m_word_msb | (W'(m_bits[k]) << (W - 1 - k));
         end
         m_hold = 1'b1;
         m_bits.delete();
      end
   endtask

   task automatic step(input bit r, input bit sv, input bit sd, input bit fs, input bit pr);
      logic [7:0] exp_cnt;
      rst = r; ser_valid = sv; ser_data = sd; frame_start = fs; par_ready = pr;
      model_update(r, sv, sd, fs, pr);
      @(posedge clk);
      #1;
      exp_cnt = m_hold ? 8'(W) : 8'(m_bits.size());
      chk("par_valid_lsb", 32'(pv_lsb), 32'(m_hold));
      chk("par_valid_msb", 32'(pv_msb), 32'(m_hold));
      chk("busy_lsb", 32'(busy_lsb), 32'(!m_hold && m_bits.size() > 0));
      chk("busy_msb", 32'(busy_msb), 32'(!m_hold && m_bits.size() > 0));
      chk("bit_count_lsb", 32'(bc_lsb), 32'(exp_cnt));
      chk("bit_count_msb", 32'(bc_msb), 32'(exp_cnt));
      chk("par_data_lsb", 32'(pd_lsb), 32'(m_word_lsb));
      chk("par_data_msb", 32'(pd_msb), 32'(m_word_msb));
      chk("overrun_lsb", 32'(ov_lsb), 32'(m_overrun));
      chk("overrun_msb", 32'(ov_msb), 32'(m_overrun));
   endtask

   initial begin
      logic [3:0] t1_bits;
      logic [7:0] t5_bits;
      assert ($bits(pd_lsb) == W) else $error("FAIL port_width: %0d vs %0d", $bits(pd_lsb), W);

      rst = 1'b1; ser_valid = 1'b0; ser_data = 1'b0; frame_start = 1'b0; par_ready = 1'b0;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset_data", 32'(pd_lsb), 32'd0);
      chk("reset_count", 32'(bc_lsb), 32'd0);

      // Test 1/2: bits 1,0,1,1, consumer ready.
      t1_bits = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         step(0, 1, t1_bits[k], k == 0, 1);
         chk("t1_count", 32'(bc_lsb), 32'(k + 1));
      end
      chk("t1_data_lsb", 32'(pd_lsb), 32'h0000000d);
      chk("t2_data_msb", 32'(pd_msb), 32'h0000000b);
      step(0, 0, 0, 0, 1);
      chk("t1_valid_one_cycle", 32'(pv_lsb), 32'd0);
      chk("t1_count_idle", 32'(bc_lsb), 32'd0);

      // Test 3: overrun while unconsumed.
      for (int k = 0; k < 4; k++) step(0, 1, t1_bits[k], k == 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("t3_data_held", 32'(pd_lsb), 32'h0000000d);
      chk("t3_overrun", 32'(ov_lsb), 32'd1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("t3_overrun_sticky", 32'(ov_lsb), 32'd1);
      chk("t3_idle", 32'(pv_lsb), 32'd0);

      // Test 4: abort after 2 bits, new frame 0,0,0,1.
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 1);
      step(0, 1, 1, 0, 1);
      step(0, 1, 0, 1, 1);
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 0, 1);
      chk("t4_data", 32'(pd_lsb), 32'h00000008);
      chk("t4_overrun", 32'(ov_lsb), 32'd0);

      // Test 5: back-to-back frames, par_ready meets next frame_start.
      step(0, 0, 0, 0, 1);
      t5_bits = 8'b0000_1111;
      for (int k = 0; k < 8; k++) begin
         step(0, 1, t5_bits[k], (k % 4) == 0, 1);
         if (k == 3) chk("t5_word0", 32'(pd_lsb), 32'h0000000f);
         if (k == 4) chk("t5_no_idle", 32'(busy_lsb), 32'd1);
      end
      chk("t5_word1", 32'(pd_lsb), 32'h00000000);
      chk("t5_overrun", 32'(ov_lsb), 32'd0);

      // Test 6: reset mid-frame, then a stray bit.
      step(0, 0, 0, 0, 1);
      step(0, 1, 1, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("t6_count3", 32'(bc_lsb), 32'd3);
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("t6_count0", 32'(bc_lsb), 32'd0);
      chk("t6_busy0", 32'(busy_lsb), 32'd0);
      chk("t6_data0", 32'(pd_lsb), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
